// File: rtl/arbitro_rr.sv
//============================================================================
// Module      : arbitro_rr
// Description : Registered N-requester bus arbiter. Fixed-priority or
//               round-robin selection, optional preemption (fixed priority
//               only) and an optional max-hold fairness limit. grant_num
//               drives the select of the shared-resource mux.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module arbitro_rr #(
  parameter  int N        = 4,   // number of requesters (>=2), index 0 = highest
  parameter  int MODE     = 0,   // 0 = fixed priority, 1 = round-robin
  parameter  int PREEMPT  = 1,   // higher-priority request steals grant (MODE=0)
  parameter  int MAX_HOLD = 0,   // max consecutive grant cycles while others wait
  localparam int W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_num,
  output logic         available
);

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
  localparam bit PREEMPT_EN = (PREEMPT != 0) && (MODE == 0);
  localparam bit HOLD_EN    = (MAX_HOLD != 0);
  localparam bit RR_EN      = (MODE == 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [W-1:0]  rr_ptr;

  // Decision signals for the next edge
  logic          take;       // load a new owner
  logic [W-1:0]  take_idx;   // index of the new owner
  logic          drop;       // return to idle
  logic          bump;       // advance the hold counter

  // Helper vectors derived from the current owner
  logic          owner_req;  // current owner still requesting
  logic [N-1:0]  higher;     // requests with higher fixed priority than owner
  logic [N-1:0]  others;     // requests from anyone except the owner
  logic [W-1:0]  base_pick;  // winner from idle or after a release
  logic [W-1:0]  pre_pick;   // winner among higher-priority requesters
  logic [W-1:0]  force_pick; // winner of a forced handoff

  // First set bit of v, scanning upward from index start and wrapping mod N.
  function automatic logic [W-1:0] pick_from(input logic [N-1:0] v, input int start);
    logic [W-1:0] res;
    logic         found;
    logic [N-1:0] sh;
    int           idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (start + i) % N;
      sh  = v >> idx;
      if (!found && sh[0]) begin
        res   = W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Grant is one-hot, so grant-1 masks every index below the owner.
  assign owner_req = |(req & grant);
  assign higher    = req & (grant - N'(1));
  assign others    = req & ~grant;

  // Candidate winners for each kind of transition
  always_comb begin
    base_pick  = RR_EN ? pick_from(req, int'(rr_ptr) + 1) : pick_from(req, 0);
    pre_pick   = pick_from(higher, 0);
    force_pick = pick_from(others, int'(grant_num) + 1);
  end

  // Next-edge decision, evaluated in the rule priority order of the BUSY state
  always_comb begin
    take     = 1'b0;
    take_idx = '0;
    drop     = 1'b0;
    bump     = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          take     = 1'b1;
          take_idx = base_pick;
        end
      end
      S_BUSY: begin
        if (!owner_req) begin
          // Release: hand straight to the next requester or go idle.
          if (|req) begin
            take     = 1'b1;
            take_idx = base_pick;
          end else begin
            drop = 1'b1;
          end
        end else if (PREEMPT_EN && (|higher)) begin
          take     = 1'b1;
          take_idx = pre_pick;
        end else if (HOLD_EN && (hold_cnt == HOLD_LAST) && (|others)) begin
          take     = 1'b1;
          take_idx = force_pick;
        end else begin
          bump = HOLD_EN && (hold_cnt != HOLD_LAST);
        end
      end
      default: drop = 1'b1;
    endcase
  end

  // Arbiter state machine with registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      grant_num <= '0;
      available <= 1'b1;
      hold_cnt  <= '0;
      rr_ptr    <= W'(N - 1);
    end else if (take) begin
      state     <= S_BUSY;
      grant     <= N'(1) << take_idx;
      grant_num <= take_idx;
      available <= 1'b0;
      hold_cnt  <= '0;
      rr_ptr    <= take_idx;
    end else if (drop) begin
      state     <= S_IDLE;
      grant     <= '0;
      grant_num <= '0;
      available <= 1'b1;
      hold_cnt  <= '0;
    end else if (bump) begin
      hold_cnt  <= hold_cnt + HW'(1);
    end
  end

  // Structural invariants of the grant outputs
  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_avail  : assert property (@(posedge clk) disable iff (rst) available == (grant == '0));
  a_num    : assert property (@(posedge clk) disable iff (rst)
                              (grant == '0) ? (grant_num == '0) : grant[grant_num]);

endmodule

`default_nettype wire
